mips_single_cycle: RTL and testbench
====================================

Name: mips_single_cycle

Overview:
- 32-bit MIPS single-cycle CPU core: fetch, decode, execute, memory access and writeback all complete in one clock.
- Contains its own byte-addressed instruction memory, byte-addressed data memory and a 32x32 register file.
- Top of the processor hierarchy. The only external pins are clock and reset; program, data and register state are preloaded by the bench through hierarchical paths.

Parameters:
- IMEM_BYTES, 128, instruction memory size in bytes (one 8-bit entry per byte).
- DMEM_BYTES, 128, data memory size in bytes (one 8-bit entry per byte).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; affects the PC only.

Behaviour:
- Bench-visible hierarchy (required names):
  - instances InstrMem, DatMem, RegFile;
  - arrays InstrMem.mem_array [IMEM_BYTES x 8], DatMem.mem_array [DMEM_BYTES x 8], RegFile.file_array [32 x 32];
  - signals pc[31:0], opcode[5:0] (instr[31:26]), funct[5:0] (instr[5:0]), rfile_wd[31:0] (register write data).
- Reset: while rst=0, pc=0 immediately (asynchronous). Memories and the register file are NOT cleared, so preloaded contents survive reset.
- Fetch: the word is little-endian from 4 bytes at pc: instr = {m[pc+3], m[pc+2], m[pc+1], m[pc]}. Reads are combinational.
- Memory addressing, both memories: the byte address is taken modulo the memory size; addr[1:0] is ignored for word accesses (forced to 00).
- Register file: two combinational read ports (rs, rt) and one write port on the clock edge. Register 0 always reads 0; writes to register 0 are ignored.
- Supported instructions, one per cycle:
  - R-type (opcode 0), result to rd:
    - ADD funct 32: rs+rt, wraps mod 2^32, no overflow trap.
    - SUB funct 34: rs-rt.
    - AND funct 36.
    - OR funct 37.
    - SLT funct 42: signed compare, result 1 or 0.
  - LW (opcode 35): rt <= little-endian word at DMEM[rs + sext(imm16)].
  - SW (opcode 43): the 4 bytes of rt are written little-endian to DMEM at rs + sext(imm16), on the clock edge.
  - BEQ (opcode 4): if rs==rt then pc <= pc+4+(sext(imm16)<<2), else pc+4.
  - J (opcode 2): pc <= {pc_plus4[31:28], target26, 2'b00}.
- rfile_wd: the ALU result for R-type, the load data for LW. Its value is don't-care for instructions that do not write.
- Unknown opcode or funct: treated as a NOP (no register or memory write, pc <= pc+4).
- Commit timing:
  - All writes (register, memory, pc) commit on the same rising edge that ends the cycle.
  - Reads in the next instruction see the new values.
  - An LW followed by a dependent instruction needs no stall.
- A reset asserted mid-cycle aborts the current instruction's pc update. Register/memory writes already committed are kept.
- pc wraps mod 2^32. Fetch beyond IMEM_BYTES wraps modulo the memory size.

Test Plan:
1. Preload reg1=5, reg2=3. Program: add $3,$1,$2; sub $4,$1,$2; and $5,$1,$2; or $6,$1,$2.
   - Required: reg3=8, reg4=2, reg5=1, reg6=7.
   - pc sequence 0,4,8,12,16; rfile_wd = 8, 2, 1, 7 in those cycles.
2. DMEM bytes 0..3 = 78 56 34 12, reg0=0. Run lw $7,0($0), then sw $7,4($0).
   - Required: reg7=0x12345678; DMEM bytes 4..7 = 78 56 34 12.
3. reg1=reg2=5: beq $1,$2,+2 at pc=0 -> next pc=12. With reg2=6 instead -> next pc=4.
4. j with target 4 at pc=8 -> next pc=16.
   - add $0,$1,$2 leaves reg0 reading 0.
   - slt with reg1=-1, reg2=1 writes 1.
5. Reset: run 3 instructions, pull rst low mid-cycle -> pc=0 immediately, register/memory contents unchanged; release -> fetch resumes at 0.
6. Undefined opcode 0x3F at pc=0 -> no state change except pc=4.

Source files
------------

// File: rtl/mips_single_cycle.sv
// Single-cycle 32-bit MIPS core (ADD/SUB/AND/OR/SLT, LW, SW, BEQ, J) with
// private byte-addressed instruction/data memories and a 32x32 register file.

module instr_mem #(
    parameter int unsigned BYTES = 128
) (
    input  logic [31:0] addr,
    output logic [31:0] rdata
);
    localparam int unsigned AW = $clog2(BYTES);

    logic [7:0]    mem_array [BYTES];
    logic [AW-1:0] idx;

    assign idx   = AW'({addr[31:2], 2'b00} % BYTES);
    assign rdata = {mem_array[idx + AW'(3)], mem_array[idx + AW'(2)],
                    mem_array[idx + AW'(1)], mem_array[idx]};
endmodule

module data_mem #(
    parameter int unsigned BYTES = 128
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int unsigned AW = $clog2(BYTES);

    logic [7:0]    mem_array [BYTES];
    logic [AW-1:0] idx;

    assign idx   = AW'({addr[31:2], 2'b00} % BYTES);
    assign rdata = {mem_array[idx + AW'(3)], mem_array[idx + AW'(2)],
                    mem_array[idx + AW'(1)], mem_array[idx]};

    // Contents are deliberately not reset so preloaded data survives rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[idx]          <= wdata[7:0];
            mem_array[idx + AW'(1)] <= wdata[15:8];
            mem_array[idx + AW'(2)] <= wdata[23:16];
            mem_array[idx + AW'(3)] <= wdata[31:24];
        end
    end
endmodule

module reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] file_array [32];

    assign rd1 = (ra1 == 5'd0) ? '0 : file_array[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : file_array[ra2];

    always_ff @(posedge clk) begin
        if (we && (wa != 5'd0)) begin
            file_array[wa] <= wd;
        end
    end
endmodule

module mips_single_cycle #(
    parameter int unsigned IMEM_BYTES = 128,
    parameter int unsigned DMEM_BYTES = 128
) (
    input logic clk,
    input logic rst
);
    typedef enum logic [5:0] {
        OP_RTYPE = 6'd0,
        OP_J     = 6'd2,
        OP_BEQ   = 6'd4,
        OP_LW    = 6'd35,
        OP_SW    = 6'd43
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'd32,
        FN_SUB = 6'd34,
        FN_AND = 6'd36,
        FN_OR  = 6'd37,
        FN_SLT = 6'd42
    } funct_e;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sext_imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_rdata;
    logic [31:0] rfile_wd;
    logic [4:0]  rfile_wa;
    logic        rfile_we;
    logic        dmem_we;
    logic        unused_shamt;

    instr_mem #(.BYTES(IMEM_BYTES)) InstrMem (
        .addr  (pc),
        .rdata (instr)
    );

    assign opcode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign sext_imm     = {{16{instr[15]}}, instr[15:0]};
    assign unused_shamt = ^instr[10:6];

    reg_file RegFile (
        .clk (clk),
        .we  (rfile_we),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (rfile_wa),
        .wd  (rfile_wd),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    assign dmem_addr = rs_val + sext_imm;

    data_mem #(.BYTES(DMEM_BYTES)) DatMem (
        .clk   (clk),
        .we    (dmem_we),
        .addr  (dmem_addr),
        .wdata (rt_val),
        .rdata (dmem_rdata)
    );

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        rfile_we = 1'b0;
        rfile_wa = rd;
        rfile_wd = '0;
        dmem_we  = 1'b0;
        pc_next  = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                rfile_we = 1'b1;
                case (funct)
                    FN_ADD:  rfile_wd = rs_val + rt_val;
                    FN_SUB:  rfile_wd = rs_val - rt_val;
                    FN_AND:  rfile_wd = rs_val & rt_val;
                    FN_OR:   rfile_wd = rs_val | rt_val;
                    FN_SLT:  rfile_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    default: rfile_we = 1'b0;
                endcase
            end
            OP_LW: begin
                rfile_we = 1'b1;
                rfile_wa = rt;
                rfile_wd = dmem_rdata;
            end
            OP_SW:  dmem_we = 1'b1;
            OP_BEQ: begin
                if (rs_val == rt_val) begin
                    pc_next = pc_plus4 + {sext_imm[29:0], 2'b00};
                end
            end
            OP_J:    pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: ;
        endcase
    end

    // Reset only steers the PC; register/memory writes of the cycle still land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

// File: tb/tb_mips_single_cycle.sv
// Directed bench for mips_single_cycle: preloads program/data/registers
// hierarchically and checks pc, write data and architectural state.

module tb_mips_single_cycle;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mips_single_cycle #(.IMEM_BYTES(128), .DMEM_BYTES(128)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic put_instr(input int unsigned a, input logic [31:0] w);
        dut.InstrMem.mem_array[7'(a)]     = w[7:0];
        dut.InstrMem.mem_array[7'(a + 1)] = w[15:8];
        dut.InstrMem.mem_array[7'(a + 2)] = w[23:16];
        dut.InstrMem.mem_array[7'(a + 3)] = w[31:24];
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        dut.RegFile.file_array[5'(r)] = v;
    endtask

    // Enter reset between edges and clear program memory to NOPs (funct 0).
    task automatic begin_test();
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 128; i++) dut.InstrMem.mem_array[7'(i)] = 8'h00;
    endtask

    task automatic release_rst(input string tag);
        check(tag, dut.pc, 32'd0);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        dut.RegFile.file_array[0] = 32'd0;

        // 1: R-type arithmetic
        begin_test();
        set_reg(1, 32'd5);
        set_reg(2, 32'd3);
        put_instr(0,  rtype(1, 2, 3, 32));
        put_instr(4,  rtype(1, 2, 4, 34));
        put_instr(8,  rtype(1, 2, 5, 36));
        put_instr(12, rtype(1, 2, 6, 37));
        release_rst("t1_reset_pc");
        check("t1_op_add", {26'd0, dut.opcode}, 32'd0);
        check("t1_fn_add", {26'd0, dut.funct}, 32'd32);
        check("t1_wd_add", dut.rfile_wd, 32'd8);
        @(negedge clk);
        check("t1_pc4", dut.pc, 32'd4);
        check("t1_wd_sub", dut.rfile_wd, 32'd2);
        @(negedge clk);
        check("t1_pc8", dut.pc, 32'd8);
        check("t1_wd_and", dut.rfile_wd, 32'd1);
        @(negedge clk);
        check("t1_pc12", dut.pc, 32'd12);
        check("t1_wd_or", dut.rfile_wd, 32'd7);
        @(negedge clk);
        check("t1_pc16", dut.pc, 32'd16);
        check("t1_reg3", dut.RegFile.file_array[3], 32'd8);
        check("t1_reg4", dut.RegFile.file_array[4], 32'd2);
        check("t1_reg5", dut.RegFile.file_array[5], 32'd1);
        check("t1_reg6", dut.RegFile.file_array[6], 32'd7);

        // 2: LW then dependent SW
        begin_test();
        dut.DatMem.mem_array[0] = 8'h78;
        dut.DatMem.mem_array[1] = 8'h56;
        dut.DatMem.mem_array[2] = 8'h34;
        dut.DatMem.mem_array[3] = 8'h12;
        for (int i = 4; i < 8; i++) dut.DatMem.mem_array[7'(i)] = 8'h00;
        set_reg(7, 32'd0);
        put_instr(0, itype(35, 0, 7, 0));
        put_instr(4, itype(43, 0, 7, 4));
        release_rst("t2_reset_pc");
        check("t2_wd_lw", dut.rfile_wd, 32'h12345678);
        @(negedge clk);
        check("t2_reg7", dut.RegFile.file_array[7], 32'h12345678);
        @(negedge clk);
        check("t2_dm4", {24'd0, dut.DatMem.mem_array[4]}, 32'h78);
        check("t2_dm5", {24'd0, dut.DatMem.mem_array[5]}, 32'h56);
        check("t2_dm6", {24'd0, dut.DatMem.mem_array[6]}, 32'h34);
        check("t2_dm7", {24'd0, dut.DatMem.mem_array[7]}, 32'h12);
        check("t2_pc8", dut.pc, 32'd8);

        // 3: BEQ taken / not taken
        begin_test();
        set_reg(1, 32'd5);
        set_reg(2, 32'd5);
        put_instr(0, itype(4, 1, 2, 2));
        release_rst("t3a_reset_pc");
        @(negedge clk);
        check("t3_beq_taken", dut.pc, 32'd12);
        begin_test();
        set_reg(2, 32'd6);
        put_instr(0, itype(4, 1, 2, 2));
        release_rst("t3b_reset_pc");
        @(negedge clk);
        check("t3_beq_not", dut.pc, 32'd4);

        // 4: J, write to $0, SLT signed
        begin_test();
        set_reg(1, 32'd5);
        set_reg(2, 32'd3);
        set_reg(10, 32'hFFFF_FFFF);
        set_reg(11, 32'd1);
        set_reg(9, 32'd0);
        set_reg(12, 32'hDEAD_BEEF);
        put_instr(8,  {6'd2, 26'd4});
        put_instr(16, rtype(1, 2, 0, 32));
        put_instr(20, rtype(10, 11, 9, 42));
        put_instr(24, rtype(0, 0, 12, 32));
        release_rst("t4_reset_pc");
        @(negedge clk);
        @(negedge clk);
        check("t4_pc8", dut.pc, 32'd8);
        @(negedge clk);
        check("t4_jump", dut.pc, 32'd16);
        @(negedge clk);
        check("t4_reg0_arr", dut.RegFile.file_array[0], 32'd0);
        check("t4_slt_wd", dut.rfile_wd, 32'd1);
        @(negedge clk);
        check("t4_reg9_slt", dut.RegFile.file_array[9], 32'd1);
        check("t4_reg0_read", dut.rfile_wd, 32'd0);
        @(negedge clk);
        check("t4_reg12", dut.RegFile.file_array[12], 32'd0);

        // 5: asynchronous reset mid-cycle
        begin_test();
        set_reg(1, 32'd5);
        set_reg(2, 32'd3);
        set_reg(6, 32'h0000_DEAD);
        put_instr(0,  rtype(1, 2, 3, 32));
        put_instr(4,  rtype(1, 2, 4, 34));
        put_instr(8,  rtype(1, 2, 5, 36));
        put_instr(12, rtype(1, 2, 6, 37));
        release_rst("t5_reset_pc");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t5_pc12", dut.pc, 32'd12);
        rst = 1'b0;
        #1;
        check("t5_async_pc", dut.pc, 32'd0);
        check("t5_reg3_kept", dut.RegFile.file_array[3], 32'd8);
        check("t5_reg5_kept", dut.RegFile.file_array[5], 32'd1);
        check("t5_reg6_untouched", dut.RegFile.file_array[6], 32'h0000_DEAD);
        check("t5_dm4_kept", {24'd0, dut.DatMem.mem_array[4]}, 32'h78);
        rst = 1'b1;
        @(negedge clk);
        check("t5_resume_pc", dut.pc, 32'd4);
        check("t5_resume_wd", dut.rfile_wd, 32'd2);

        // 6: undefined opcode is a NOP
        begin_test();
        set_reg(1, 32'd0);
        set_reg(2, 32'h0000_0016);
        set_reg(3, 32'h0000_0033);
        put_instr(0, {6'h3F, 5'd1, 5'd2, 16'h1800});
        release_rst("t6_reset_pc");
        @(negedge clk);
        check("t6_pc4", dut.pc, 32'd4);
        check("t6_reg2", dut.RegFile.file_array[2], 32'h0000_0016);
        check("t6_reg3", dut.RegFile.file_array[3], 32'h0000_0033);
        check("t6_dm0", {24'd0, dut.DatMem.mem_array[0]}, 32'h78);
        check("t6_dm4", {24'd0, dut.DatMem.mem_array[4]}, 32'h78);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
